// File: rtl/oam_dma_ctrl.sv
// OAM DMA: a CPU write to $4014 halts the 6502 and copies {page,00..FF} to $2004 (513 stall cycles, 514 with ALIGN).
// The CPU is held off through rdy only; define OAM_DMA_ALIGN_EN to add the get/put ALIGN cycle.
module oam_dma_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  bus_din,
  output logic        rdy,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_dout,
  output logic        dma_active
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t     state;
  logic [7:0] count;
  logic [7:0] page;
  logic [7:0] data;
  logic       start;

  assign start = !cpu_rw && (cpu_addr == 16'h4014);

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity <= 1'b0;
    else      parity <= ~parity;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      page  <= '0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            page  <= cpu_dout;
            count <= '0;
            state <= HALT;
          end
        end
        HALT: begin
          // Halt cycle on put (parity 1) means the next cycle is a get, so READ can start at once.
          if (cpu_rw) begin
`ifdef OAM_DMA_ALIGN_EN
            state <= parity ? READ : ALIGN;
`else
            state <= READ;
`endif
          end
        end
`ifdef OAM_DMA_ALIGN_EN
        ALIGN: state <= READ;
`endif
        READ: begin
          data  <= bus_din;
          state <= WRITE;
        end
        WRITE: begin
          count <= count + 8'd1;
          state <= (count == 8'hFF) ? IDLE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdy        = (state == IDLE);
    dma_active = (state == READ) || (state == WRITE);
    bus_addr   = cpu_addr;
    bus_rw     = cpu_rw;
    bus_dout   = cpu_dout;
    case (state)
      READ: begin
        bus_addr = {page, count};
        bus_rw   = 1'b1;
      end
      WRITE: begin
        bus_addr = 16'h2004;
        bus_rw   = 1'b0;
        bus_dout = data;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: reset/passthrough vector table plus hand-written DMA transfer sequences.
module tb_oam_dma_ctrl;
  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic [7:0]  bus_din;
  logic        rdy;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_dout;
  logic        dma_active;
  logic        tb_par;

  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ {a[3:0], a[15:12]} ^ 8'h3C;
  endfunction

  assign bus_din = mem_val(bus_addr);

  oam_dma_ctrl dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_dout(cpu_dout),
    .bus_din(bus_din), .rdy(rdy), .bus_addr(bus_addr), .bus_rw(bus_rw),
    .bus_dout(bus_dout), .dma_active(dma_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // get/put phase as seen by the CPU: 0 on the first cycle after reset, toggling every clock
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_par <= 1'b0;
    else      tb_par <= ~tb_par;
  end

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  dout;
    logic        exp_rdy;
    logic        exp_act;
    logic [15:0] exp_addr;
    logic        exp_rw;
    logic [7:0]  exp_dout;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic go_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_addr = 16'h8000;
    cpu_rw   = 1'b1;
    cpu_dout = 8'h00;
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] pg, input int n_rw0,
                          input logic halt_put, input logic poke, input logic do_rst);
    int rd_n, wr_n, bad_rd, bad_wr, pt_bad, low_n, pre_n, first_rd, align_exp;
    logic wpar, done, poked;
    logic [15:0] last_rd;
    rd_n = 0; wr_n = 0; bad_rd = 0; bad_wr = 0; pt_bad = 0;
    low_n = 0; pre_n = 0; first_rd = -1;
    done = 1'b0; poked = 1'b0; last_rd = '0;
`ifdef OAM_DMA_ALIGN_EN
    align_exp = halt_put ? 0 : 1;
`else
    align_exp = 0;
`endif
    wpar = halt_put ^ (((n_rw0 + 1) % 2) == 1);

    go_cycle();
    if (tb_par != wpar) go_cycle();
    cpu_addr = 16'h4014;
    cpu_rw   = 1'b0;
    cpu_dout = pg;
    @(negedge clk);
    chk({tag, "_start_idle"}, {62'd0, rdy, dma_active}, 64'd2);

    for (int k = 0; k < 600 && !done; k++) begin
      go_cycle();
      if (k < n_rw0) begin
        cpu_addr = 16'h01FF - 16'(k);
        cpu_rw   = 1'b0;
        cpu_dout = 8'hC0 + 8'(k);
      end else if (poke && !poked && rd_n == 17) begin
        cpu_addr = 16'h4014;
        cpu_rw   = 1'b0;
        cpu_dout = 8'h07;
        poked    = 1'b1;
      end else begin
        cpu_idle();
      end
      @(negedge clk);
      if (rdy) begin
        done = 1'b1;
      end else begin
        low_n++;
        if (!dma_active) begin
          pre_n++;
          if (bus_addr !== cpu_addr || bus_rw !== cpu_rw || bus_dout !== cpu_dout) pt_bad++;
        end else if (bus_rw) begin
          if (first_rd < 0) first_rd = k;
          if (bus_addr !== {pg, 8'(rd_n)}) bad_rd++;
          last_rd = bus_addr;
          rd_n++;
        end else begin
          if (bus_addr !== 16'h2004 || bus_dout !== mem_val({pg, 8'(wr_n)})) bad_wr++;
          if (do_rst && wr_n == 64) begin
            #1 rst = 1'b0;
            #1;
            chk({tag, "_rst_async"}, 64'({rdy, dma_active, bus_addr, bus_rw, bus_dout}),
                64'({1'b1, 1'b0, cpu_addr, cpu_rw, cpu_dout}));
            @(posedge clk);
            #1 rst = 1'b1;
            for (int j = 0; j < 3; j++) begin
              go_cycle();
              cpu_addr = 16'h0300 + 16'(j);
              cpu_rw   = 1'b0;
              cpu_dout = 8'h90 + 8'(j);
              @(negedge clk);
              if (!rdy || dma_active || bus_addr !== cpu_addr || bus_rw !== cpu_rw ||
                  bus_dout !== cpu_dout) pt_bad++;
            end
            cpu_idle();
            done = 1'b1;
          end
          wr_n++;
        end
      end
    end

    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_bad_rd"}, 64'(bad_rd), 64'd0);
    chk({tag, "_bad_wr"}, 64'(bad_wr), 64'd0);
    chk({tag, "_passthru"}, 64'(pt_bad), 64'd0);
    if (!do_rst) begin
      chk({tag, "_rdy_low"}, 64'(low_n), 64'(n_rw0 + 513 + align_exp));
      chk({tag, "_pre_dma"}, 64'(pre_n), 64'(n_rw0 + 1 + align_exp));
      chk({tag, "_first_rd"}, 64'(first_rd), 64'(n_rw0 + 1 + align_exp));
      chk({tag, "_reads"}, 64'(rd_n), 64'd256);
      chk({tag, "_writes"}, 64'(wr_n), 64'd256);
      chk({tag, "_last_rd"}, 64'(last_rd), 64'({pg, 8'hFF}));
    end else begin
      chk({tag, "_writes_before_rst"}, 64'(wr_n), 64'd65);
    end
  endtask

  vec_t vecs[8];

  initial begin
    rst      = 1'b0;
    cpu_addr = 16'h0000;
    cpu_rw   = 1'b1;
    cpu_dout = 8'h00;

    vecs[0] = '{1'b0, 16'h1234, 1'b1, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 16'h4014, 1'b0, 8'h02, 1'b1, 1'b0, 16'h4014, 1'b0, 8'h02};
    vecs[2] = '{1'b0, 16'hABCD, 1'b0, 8'h5A, 1'b1, 1'b0, 16'hABCD, 1'b0, 8'h5A};
    vecs[3] = '{1'b1, 16'h4014, 1'b1, 8'h33, 1'b1, 1'b0, 16'h4014, 1'b1, 8'h33};
    vecs[4] = '{1'b1, 16'h4015, 1'b0, 8'h02, 1'b1, 1'b0, 16'h4015, 1'b0, 8'h02};
    vecs[5] = '{1'b1, 16'h4013, 1'b0, 8'h02, 1'b1, 1'b0, 16'h4013, 1'b0, 8'h02};
    vecs[6] = '{1'b1, 16'h0000, 1'b0, 8'hFF, 1'b1, 1'b0, 16'h0000, 1'b0, 8'hFF};
    vecs[7] = '{1'b1, 16'hFFFF, 1'b1, 8'h81, 1'b1, 1'b0, 16'hFFFF, 1'b1, 8'h81};

    for (int i = 0; i < 8; i++) begin
      go_cycle();
      rst      = vecs[i].rst;
      cpu_addr = vecs[i].addr;
      cpu_rw   = vecs[i].rw;
      cpu_dout = vecs[i].dout;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 64'({rdy, dma_active, bus_addr, bus_rw, bus_dout}),
          64'({vecs[i].exp_rdy, vecs[i].exp_act, vecs[i].exp_addr, vecs[i].exp_rw, vecs[i].exp_dout}));
    end
    cpu_idle();

    run_xfer("put_p02",  8'h02, 0, 1'b1, 1'b0, 1'b0);
    run_xfer("get_p02",  8'h02, 0, 1'b0, 1'b0, 1'b0);
    run_xfer("hold3",    8'h05, 3, 1'b1, 1'b0, 1'b0);
    run_xfer("poke4014", 8'h03, 0, 1'b1, 1'b1, 1'b0);
    run_xfer("pageFF",   8'hFF, 0, 1'b0, 1'b0, 1'b0);
    run_xfer("midrst",   8'h04, 0, 1'b1, 1'b0, 1'b1);
    run_xfer("after_rst", 8'h01, 0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
